// File: rtl/fstage_bus_pkg.sv
// Shared definitions for the fetch-stage bus master.
package fstage_bus_pkg;

  localparam int unsigned INST_WIDTH       = 32;
  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  // Fetch FSM: address phase, data phase, present to decode, wait for next PC.
  typedef enum logic [1:0] {
    StAr,
    StR,
    StHold,
    StWaitNpc
  } fstage_state_e;

endpackage

// File: rtl/fstage_bus.sv
// Instruction fetch stage: one read transaction at a time on an AXI-lite style
// read channel, presenting the fetched word to decode with a valid/ready pair.
module fstage_bus
  import fstage_bus_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [31:0]           ifu_araddr,
  output logic                  ifu_arvalid,
  input  logic                  ifu_arready,
  input  logic [31:0]           ifu_rdata,
  input  logic [1:0]            ifu_rresp,
  input  logic                  ifu_rvalid,
  output logic                  ifu_rready,
  output logic [INST_WIDTH-1:0] instF,
  output logic [31:0]           pcF,
  output logic [31:0]           snpcF,
  output logic                  fetch_err,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  npc_valid,
  input  logic [31:0]           npc
);

  fstage_state_e         state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic                  err_q, err_d;

  // State and fetch-result registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StAr;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; rvalid is only looked at in StR, so a stale response is dropped.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    err_d   = err_q;
    unique case (state_q)
      StAr: begin
        if (ifu_arready) state_d = StR;
      end
      StR: begin
        if (ifu_rvalid) begin
          inst_d  = ifu_rdata;
          err_d   = (ifu_rresp != RESP_OKAY);
          state_d = StHold;
        end
      end
      StHold: begin
        if (m_ready) state_d = StWaitNpc;
      end
      StWaitNpc: begin
        if (npc_valid) begin
          pc_d = npc;
          if (npc[1:0] == 2'b00) begin
            state_d = StAr;
          end else begin
            // Misaligned target: report a fault without touching the bus.
            inst_d  = '0;
            err_d   = 1'b1;
            state_d = StHold;
          end
        end
      end
      default: state_d = StAr;
    endcase
  end

  // Outputs decoded from state; handshakes are gated off while reset is held.
  always_comb begin
    ifu_araddr  = pc_q;
    ifu_arvalid = rst & (state_q == StAr);
    ifu_rready  = rst & (state_q == StR);
    m_valid     = rst & (state_q == StHold);
    instF       = inst_q;
    pcF         = pc_q;
    snpcF       = pc_q + 32'd4;
    fetch_err   = err_q;
  end

endmodule

// File: tb/tb_fstage_bus.sv
// Randomised bench for fstage_bus: a bus responder and decode/writeback driver
// push expected fetch results into a queue; a monitor checks every presented result.
module tb_fstage_bus;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid, ifu_arready;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rvalid, ifu_rready;
  logic [31:0] instF, pcF, snpcF;
  logic        fetch_err, m_valid, m_ready, npc_valid;
  logic [31:0] npc;

  fstage_bus #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .ifu_araddr (ifu_araddr),
    .ifu_arvalid(ifu_arvalid),
    .ifu_arready(ifu_arready),
    .ifu_rdata  (ifu_rdata),
    .ifu_rresp  (ifu_rresp),
    .ifu_rvalid (ifu_rvalid),
    .ifu_rready (ifu_rready),
    .instF      (instF),
    .pcF        (pcF),
    .snpcF      (snpcF),
    .fetch_err  (fetch_err),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .npc_valid  (npc_valid),
    .npc        (npc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: whenever decode sees a valid result it must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && m_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_m_valid", 32'd1, 32'd0);
      end else begin
        chk("instF", instF, q[0].inst);
        chk("pcF", pcF, q[0].pc);
        chk("snpcF", snpcF, q[0].pc + 32'd4);
        chk("fetch_err", {31'd0, fetch_err}, {31'd0, q[0].err});
        if (m_ready) void'(q.pop_front());
      end
    end
  end

  // Abstract model state: 0 address phase, 1 data phase, 2 presenting, 3 awaiting next PC.
  int          mst;
  int          last_mst;
  int          stall;
  int          ar_wait;
  int          fetch_no;
  int          npc_no;
  int          hold_cycles;
  bit          did_reset;
  logic [31:0] model_pc;
  logic [31:0] rd;
  logic [1:0]  rr;
  logic [2:0]  exp_vec;

  initial begin
    rst = 1'b0; ifu_arready = 1'b0; ifu_rvalid = 1'b0; ifu_rdata = '0; ifu_rresp = '0;
    m_ready = 1'b0; npc_valid = 1'b0; npc = '0;
    mst = 0; last_mst = 0; stall = 0; ar_wait = 0; fetch_no = 0; npc_no = 0;
    hold_cycles = 0; did_reset = 1'b0; model_pc = RST_PC;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_handshakes", {29'd0, ifu_arvalid, ifu_rready, m_valid}, 32'd0);
    chk("reset_instF", instF, 32'd0);
    chk("reset_fetch_err", {31'd0, fetch_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      if (mst == 1 && model_pc == 32'h8000_0100 && !did_reset) begin
        // Abandon an in-flight read, then offer a stale response in the address phase.
        did_reset = 1'b1;
        rst = 1'b0;
        #1;
        chk("midreset_handshakes", {29'd0, ifu_arvalid, ifu_rready, m_valid}, 32'd0);
        chk("midreset_instF", instF, 32'd0);
        chk("midreset_fetch_err", {31'd0, fetch_err}, 32'd0);
        q.delete();
        mst = 0; model_pc = RST_PC; ar_wait = 1;
        ifu_arready = 1'b0; ifu_rvalid = 1'b1; ifu_rdata = 32'hBAD0_BAD0; ifu_rresp = 2'b00;
        m_ready = 1'b0; npc_valid = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        continue;
      end

      case (mst)
        0:       exp_vec = 3'b100;
        1:       exp_vec = 3'b010;
        2:       exp_vec = 3'b001;
        default: exp_vec = 3'b000;
      endcase
      chk("handshake_outputs", {29'd0, ifu_arvalid, ifu_rready, m_valid}, {29'd0, exp_vec});
      if (mst == 0) chk("araddr", ifu_araddr, model_pc);

      if (mst == last_mst) stall++;
      else stall = 0;
      last_mst = mst;
      if (stall > 60) begin
        chk("progress_timeout", 32'd1, 32'd0);
        break;
      end

      // Defaults: spurious traffic that the current state must ignore.
      ifu_arready = 1'b0;
      ifu_rvalid  = ($urandom_range(0, 2) == 0);
      ifu_rdata   = $urandom;
      ifu_rresp   = 2'($urandom_range(0, 3));
      m_ready     = ($urandom_range(0, 1) == 1);
      npc_valid   = ($urandom_range(0, 3) == 0);
      npc         = $urandom;

      case (mst)
        0: begin
          ifu_arready = (ar_wait == 0);
          if (ar_wait > 0) ar_wait--;
          if (ifu_arready) mst = 1;
        end
        1: begin
          ifu_rvalid = ($urandom_range(0, 2) != 0);
          if (fetch_no == 0) begin
            rd = 32'h0000_0413; rr = 2'b00;
          end else if (fetch_no == 1) begin
            rd = 32'hDEAD_BEEF; rr = 2'b10;
          end else begin
            rd = $urandom;
            rr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
          end
          ifu_rdata = rd;
          ifu_rresp = rr;
          if (ifu_rvalid) begin
            q.push_back('{inst: rd, pc: model_pc, err: (rr != 2'b00)});
            fetch_no++;
            hold_cycles = 0;
            mst = 2;
          end
        end
        2: begin
          // First result is held for five cycles to check it stays put.
          if (fetch_no == 1 && hold_cycles < 5) m_ready = 1'b0;
          hold_cycles++;
          if (m_ready) mst = 3;
        end
        default: begin
          npc_valid = ($urandom_range(0, 1) == 1);
          if (npc_valid) begin
            if (npc_no == 0) npc = 32'h8000_0100;
            else if (npc_no == 1) npc = 32'h8000_0102;
            else if (npc_no == 2) npc = 32'hFFFF_FFFC;
            else if ($urandom_range(0, 4) == 0) npc = {$urandom_range(0, 32'hFFFF) , 16'h0}
                                                      | 32'($urandom_range(1, 3));
            else npc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            model_pc = npc;
            if (npc % 4 == 0) begin
              ar_wait = (npc_no == 0) ? 3 : $urandom_range(0, 2);
              mst = 0;
            end else begin
              q.push_back('{inst: 32'd0, pc: npc, err: 1'b1});
              hold_cycles = 0;
              mst = 2;
            end
            npc_no++;
          end
        end
      endcase
    end

    chk("fetches_completed", {31'd0, (fetch_no > 20)}, 32'd1);
    chk("reset_case_reached", {31'd0, did_reset}, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
